sfp_frame_parser: RTL and testbench

SFP_FRAME_PARSER -- requirements
Module: sfp_frame_parser

---
 rtl/sfp_pkg.sv | 37 +++
 rtl/sfp_chksum_acc.sv | 25 ++
 rtl/sfp_frame_parser.sv | 194 +++++++++++++++++++
 tb/tb_sfp_frame_parser.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// Shared definitions for the SFP RX frame parser: K-codes, FSM states, error codes
// and the word classifier.
package sfp_pkg;

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_SOF  = 8'hFB;
  localparam logic [7:0] K_EOF  = 8'hFD;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BAD_LEN = 3'd1;
  localparam logic [2:0] ERR_RESTART = 3'd2;
  localparam logic [2:0] ERR_SHORT   = 3'd3;
  localparam logic [2:0] ERR_BAD_K   = 3'd4;
  localparam logic [2:0] ERR_LONG    = 3'd5;
  localparam logic [2:0] ERR_CHKSUM  = 3'd6;

  typedef enum logic [1:0] {StIdle, StPayload, StWaitEof} state_e;

  typedef enum logic [2:0] {WcIdle, WcSof, WcEof, WcData, WcIllegal} word_class_e;

  function automatic word_class_e classify(input logic [3:0] charisk, input logic [7:0] byte0);
    word_class_e wc;
    wc = WcIllegal;
    if (charisk == 4'b0000) begin
      wc = WcData;
    end else if (charisk == 4'b0001) begin
      case (byte0)
        K_IDLE:  wc = WcIdle;
        K_SOF:   wc = WcSof;
        K_EOF:   wc = WcEof;
        default: wc = WcIllegal;
      endcase
    end
    return wc;
  endfunction

endpackage

// File: rtl/sfp_chksum_acc.sv
// 16-bit payload checksum: sums both halves of each enabled 32-bit word, modulo 2^16.
module sfp_chksum_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [15:0] sum
);

  logic [15:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_q + din[31:16] + din[15:0];
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/sfp_frame_parser.sv
// SFP RX frame parser: splits an aligned K-coded stream into payload words plus frame status.
// Optional checksum verification is enabled by defining SFP_RX_CHKSUM_EN.
module sfp_frame_parser #(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rx_data_in,
  input  logic [3:0]  rx_charisk_in,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_eof,
  output logic [7:0]  m_type,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);
  import sfp_pkg::*;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        first_q, first_d;
  logic [31:0] data_q;
  logic        valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic        ok_q, ok_d, err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] ok_cnt_q, err_cnt_q;

  word_class_e wc;
  logic [15:0] sof_len;
  logic        len_ok;
  logic        chk_ok;

  assign wc      = classify(rx_charisk_in, rx_data_in[7:0]);
  assign sof_len = rx_data_in[23:8];
  assign len_ok  = (sof_len != 16'd0) && ({16'd0, sof_len} <= MAX_LEN);

`ifdef SFP_RX_CHKSUM_EN
  logic [15:0] acc_sum;
  logic        acc_clr, acc_en;

  assign acc_clr = (wc == WcSof) && len_ok;
  assign acc_en  = (state_q == StPayload) && (wc == WcData);

  sfp_chksum_acc u_chksum_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (rx_data_in),
    .sum   (acc_sum)
  );

  assign chk_ok = (rx_data_in[31:16] == acc_sum);
`else
  assign chk_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    type_d  = type_q;

    // A SOF is handled identically in every state; outside IDLE it also flags RESTART.
    if (wc == WcSof) begin
      if (state_q != StIdle) begin
        err_d  = 1'b1;
        code_d = ERR_RESTART;
      end
      if (len_ok) begin
        cnt_d   = sof_len;
        first_d = 1'b1;
        type_d  = rx_data_in[31:24];
        state_d = StPayload;
      end else begin
        state_d = StIdle;
        if (state_q == StIdle) begin
          err_d  = 1'b1;
          code_d = ERR_BAD_LEN;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StPayload: begin
          case (wc)
            WcData: begin
              valid_d = 1'b1;
              sof_d   = first_q;
              first_d = 1'b0;
              cnt_d   = cnt_q - 16'd1;
              if (cnt_q == 16'd1) begin
                eof_d   = 1'b1;
                state_d = StWaitEof;
              end
            end
            WcEof: begin
              err_d   = 1'b1;
              code_d  = ERR_SHORT;
              state_d = StIdle;
            end
            WcIllegal: begin
              err_d   = 1'b1;
              code_d  = ERR_BAD_K;
              state_d = StIdle;
            end
            default: ;
          endcase
        end
        StWaitEof: begin
          case (wc)
            WcEof: begin
              if (chk_ok) begin
                ok_d = 1'b1;
              end else begin
                err_d  = 1'b1;
                code_d = ERR_CHKSUM;
              end
              state_d = StIdle;
            end
            WcData: begin
              err_d   = 1'b1;
              code_d  = ERR_LONG;
              state_d = StIdle;
            end
            default: ;
          endcase
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      type_q    <= '0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      if (valid_d) begin
        data_q <= rx_data_in;
      end
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
      type_q  <= type_d;
      if (ok_d && (ok_cnt_q != 16'hFFFF)) begin
        ok_cnt_q <= ok_cnt_q + 16'd1;
      end
      if (err_d && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign m_sof     = sof_q;
  assign m_eof     = eof_q;
  assign m_type    = type_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign ok_cnt    = ok_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sfp_frame_parser.sv
// Directed bench for sfp_frame_parser with a scoreboard of expected payload words and
// frame status pulses.
module tb_sfp_frame_parser;

  localparam int unsigned MaxLen = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] rx_data_in;
  logic [3:0]  rx_charisk_in;
  logic [31:0] m_data;
  logic        m_valid, m_sof, m_eof;
  logic [7:0]  m_type;
  logic        frame_ok, frame_err;
  logic [2:0]  err_code;
  logic [15:0] ok_cnt, err_cnt;

  sfp_frame_parser #(.MAX_LEN(MaxLen)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data_in    (rx_data_in),
    .rx_charisk_in (rx_charisk_in),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_sof         (m_sof),
    .m_eof         (m_eof),
    .m_type        (m_type),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .ok_cnt        (ok_cnt),
    .err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
    logic [7:0]  typ;
  } word_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] code;
  } stat_t;

  word_t wq[$];
  stat_t sq[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_ok = 0;
  int    exp_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_word(input logic [31:0] d, input logic sof, input logic eof,
                                    input logic [7:0] typ);
    word_t w;
    w.data = d;
    w.sof  = sof;
    w.eof  = eof;
    w.typ  = typ;
    wq.push_back(w);
  endfunction

  function automatic void push_stat(input logic ok, input logic [2:0] code);
    stat_t s;
    s.ok   = ok;
    s.code = code;
    sq.push_back(s);
    if (ok) exp_ok++;
    else exp_err++;
  endfunction

  task automatic drive(input logic [3:0] k, input logic [31:0] d);
    @(posedge clk);
    #1;
    rx_charisk_in = k;
    rx_data_in    = d;
  endtask

  task automatic idle_w(input int n);
    for (int i = 0; i < n; i++) drive(4'b0001, 32'h0000_00BC);
  endtask

  task automatic sof_w(input logic [15:0] len, input logic [7:0] typ);
    drive(4'b0001, {typ, len, 8'hFB});
  endtask

  task automatic eof_w(input logic [15:0] chk);
    drive(4'b0001, {chk, 8'h00, 8'hFD});
  endtask

  task automatic data_w(input logic [31:0] d);
    drive(4'b0000, d);
  endtask

  // Complete frame of n words; bad_chk corrupts the trailing checksum by one.
  task automatic frame(input int n, input logic [7:0] typ, input logic [31:0] base,
                       input logic bad_chk);
    logic [15:0] sum;
    logic [31:0] d;
    sum = '0;
    sof_w(16'(n), typ);
    for (int i = 0; i < n; i++) begin
      d = base + 32'(i) * 32'h0002_0002;
      push_word(d, i == 0, i == n - 1, typ);
      sum = sum + d[31:16] + d[15:0];
      data_w(d);
    end
`ifdef SFP_RX_CHKSUM_EN
    push_stat(!bad_chk, bad_chk ? 3'd6 : 3'd0);
`else
    push_stat(1'b1, 3'd0);
`endif
    eof_w(sum + {15'd0, bad_chk});
    idle_w(1);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_valid === 1'b1) begin
        if (wq.size() == 0) begin
          check("unexpected_m_valid", {31'd0, m_valid}, 32'd0);
        end else begin
          word_t w;
          w = wq.pop_front();
          check("m_data", m_data, w.data);
          check("m_sof", {31'd0, m_sof}, {31'd0, w.sof});
          check("m_eof", {31'd0, m_eof}, {31'd0, w.eof});
          if (w.sof) check("m_type", {24'd0, m_type}, {24'd0, w.typ});
        end
      end
      if (frame_ok === 1'b1 || frame_err === 1'b1) begin
        if (sq.size() == 0) begin
          check("unexpected_status", {30'd0, frame_ok, frame_err}, 32'd0);
        end else begin
          stat_t s;
          s = sq.pop_front();
          check("frame_ok", {31'd0, frame_ok}, {31'd0, s.ok});
          check("frame_err", {31'd0, frame_err}, {31'd0, !s.ok});
          if (!s.ok) check("err_code", {29'd0, err_code}, {29'd0, s.code});
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_data"}, m_data, 32'd0);
    check({tag, "_m_valid"}, {29'd0, m_valid, m_sof, m_eof}, 32'd0);
    check({tag, "_m_type"}, {24'd0, m_type}, 32'd0);
    check({tag, "_status"}, {30'd0, frame_ok, frame_err}, 32'd0);
    check({tag, "_err_code"}, {29'd0, err_code}, 32'd0);
    check({tag, "_cnts"}, {ok_cnt, err_cnt}, 32'd0);
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_ok_cnt"}, {16'd0, ok_cnt}, 32'(exp_ok));
    check({tag, "_err_cnt"}, {16'd0, err_cnt}, 32'(exp_err));
  endtask

  initial begin
    rst_n         = 1'b1;
    rx_charisk_in = 4'b0001;
    rx_data_in    = 32'h0000_00BC;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    #20 rst_n = 1'b1;
    idle_w(2);

    // Three-word frame with the correct checksum 16'h0015.
    frame(3, 8'h21, 32'h0001_0002, 1'b0);
    idle_w(1);
    check("type_held", {24'd0, m_type}, 32'h21);
    check_cnts("frame_a");

    // Same frame, checksum 16'h0016.
    frame(3, 8'h22, 32'h0001_0002, 1'b1);

    // Out-of-range lengths.
    push_stat(1'b0, 3'd1);
    sof_w(16'd0, 8'h30);
    push_stat(1'b0, 3'd1);
    sof_w(16'(MaxLen + 1), 8'h31);
    idle_w(2);
    check_cnts("bad_len");

    // Longest legal frame.
    frame(MaxLen, 8'h32, 32'h1000_2000, 1'b0);

    // Restart mid-payload, then a one-word frame.
    sof_w(16'd4, 8'h37);
    push_word(32'hA0A0_0001, 1'b1, 1'b0, 8'h37);
    data_w(32'hA0A0_0001);
    push_word(32'hA0A0_0002, 1'b0, 1'b0, 8'h37);
    data_w(32'hA0A0_0002);
    push_stat(1'b0, 3'd2);
    sof_w(16'd1, 8'h38);
    push_word(32'h0003_0004, 1'b1, 1'b1, 8'h38);
    data_w(32'h0003_0004);
    push_stat(1'b1, 3'd0);
    eof_w(16'h0007);
    idle_w(2);

    // Idle insertion, then one word too many.
    sof_w(16'd2, 8'h40);
    push_word(32'h1111_2222, 1'b1, 1'b0, 8'h40);
    data_w(32'h1111_2222);
    idle_w(3);
    push_word(32'h3333_4444, 1'b0, 1'b1, 8'h40);
    data_w(32'h3333_4444);
    push_stat(1'b0, 3'd5);
    data_w(32'h5555_6666);
    idle_w(2);

    // EOF after one of two words.
    sof_w(16'd2, 8'h41);
    push_word(32'h7777_8888, 1'b1, 1'b0, 8'h41);
    data_w(32'h7777_8888);
    push_stat(1'b0, 3'd3);
    eof_w(16'h0000);
    idle_w(2);

    // Illegal K character mid-payload.
    sof_w(16'd2, 8'h42);
    push_word(32'h9999_AAAA, 1'b1, 1'b0, 8'h42);
    data_w(32'h9999_AAAA);
    push_stat(1'b0, 3'd4);
    drive(4'b0011, 32'h0000_00BC);
    idle_w(2);

    // Words outside a frame are ignored silently.
    data_w(32'hDEAD_BEEF);
    eof_w(16'h1234);
    drive(4'b0001, 32'h0000_00AA);
    drive(4'b1000, 32'h0000_0000);
    idle_w(3);
    check_cnts("mid");
    check("err_code_held", {29'd0, err_code}, 32'd4);

    // Reset during payload discards the frame.
    sof_w(16'd3, 8'h50);
    push_word(32'h0101_0202, 1'b1, 1'b0, 8'h50);
    data_w(32'h0101_0202);
    idle_w(2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    exp_ok  = 0;
    exp_err = 0;
    idle_w(2);
    check_reset_outputs("held_reset");
    #2 rst_n = 1'b1;
    idle_w(1);
    frame(2, 8'h60, 32'h0001_0001, 1'b0);
    idle_w(3);
    check_cnts("after_reset");
    check("word_queue_empty", 32'(wq.size()), 32'd0);
    check("stat_queue_empty", 32'(sq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
